// File: rtl/tx_iq_dac_pacer_pkg.sv
// Shared types and width helpers for the tx I/Q DAC pacer.
`timescale 1ns/1ps
package tx_iq_dac_pacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_ACTIVE,
        ST_TAIL
    } pacer_state_t;

    // Signed product of one lane and an unsigned gain of up to 2^ramp_shift.
    function automatic int gain_prod_width(input int iq_width, input int ramp_shift);
        return iq_width + ramp_shift + 1;
    endfunction

    function automatic int sample_width(input int iq_width);
        return 2 * iq_width;
    endfunction

endpackage

// File: rtl/tx_iq_dac_pacer_ramp_gain.sv
// Registered two-lane signed scaler: y = (x * gain) >>> RAMP_SHIFT, floor rounding.
`timescale 1ns/1ps
module tx_ramp_gain
    import tx_iq_dac_pacer_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int RAMP_SHIFT    = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            sample_valid,
    input  logic signed [IQ_DATA_WIDTH-1:0] x0,
    input  logic signed [IQ_DATA_WIDTH-1:0] x1,
    input  logic        [RAMP_SHIFT:0]      gain,
    output logic                            scaled_valid,
    output logic signed [IQ_DATA_WIDTH-1:0] y0,
    output logic signed [IQ_DATA_WIDTH-1:0] y1
);

    localparam int PROD_W = gain_prod_width(IQ_DATA_WIDTH, RAMP_SHIFT);

    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod0;
    logic signed [PROD_W-1:0] prod1;

    // Gain is at most 2^RAMP_SHIFT, so the shifted result always fits one lane.
    assign gain_ext = signed'(PROD_W'(gain));
    assign prod0    = PROD_W'(x0) * gain_ext;
    assign prod1    = PROD_W'(x1) * gain_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scaled_valid <= 1'b0;
            y0           <= '0;
            y1           <= '0;
        end else begin
            scaled_valid <= sample_valid;
            if (sample_valid) begin
                y0 <= IQ_DATA_WIDTH'(prod0 >>> RAMP_SHIFT);
                y1 <= IQ_DATA_WIDTH'(prod1 >>> RAMP_SHIFT);
            end
        end
    end

endmodule

// File: rtl/tx_iq_dac_pacer.sv
// Paces the upstream tx I/Q stage, ramps burst starts, tracks burst activity and drives the DAC bus.
`timescale 1ns/1ps
module tx_iq_dac_pacer
    import tx_iq_dac_pacer_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int RAMP_SHIFT    = 4,
    parameter int TAIL_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [7:0]                   rate_div,
    input  logic [TAIL_WIDTH-1:0]        tail_len,
    input  logic                         ramp_en,
    input  logic                         iq_swap,
    input  logic [2*IQ_DATA_WIDTH-1:0]   wifi_iq_pack,
    input  logic                         wifi_iq_valid,
    output logic                         wifi_iq_ready,
    output logic [2*IQ_DATA_WIDTH-1:0]   dac_data,
    output logic                         dac_valid,
    output logic                         tx_active,
    output logic                         underrun
);

    localparam int SW = sample_width(IQ_DATA_WIDTH);
    localparam logic [RAMP_SHIFT-1:0] K_LAST     = '1;
    localparam logic [RAMP_SHIFT-1:0] K_ONE      = RAMP_SHIFT'(1);
    localparam logic [RAMP_SHIFT-1:0] K_SECOND   = RAMP_SHIFT'(2);
    localparam logic [RAMP_SHIFT:0]   UNITY_GAIN = {1'b1, {RAMP_SHIFT{1'b0}}};

    logic [7:0]               div_cnt;
    logic                     div_hit;
    logic                     ready_d;
    logic                     cap_valid;
    logic [SW-1:0]            cap_data;
    logic                     cap_zero;
    pacer_state_t             state, state_next;
    logic [RAMP_SHIFT-1:0]    k_reg, k_next;
    logic [TAIL_WIDTH-1:0]    tail_cnt, tail_next;
    logic [TAIL_WIDTH:0]      tail_limit, tail_after;
    logic [RAMP_SHIFT:0]      gain;
    logic [IQ_DATA_WIDTH-1:0] lane0, lane1, y0, y1;

    // A lowered rate_div below the running count is caught by the 255 wrap.
    assign div_hit = (div_cnt == rate_div);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt       <= '0;
            wifi_iq_ready <= 1'b0;
        end else begin
            wifi_iq_ready <= div_hit;
            if (div_hit || div_cnt == 8'hFF) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_d   <= 1'b0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
            underrun  <= 1'b0;
        end else begin
            ready_d   <= wifi_iq_ready;
            cap_valid <= ready_d;
            if (ready_d) begin
                cap_data <= wifi_iq_valid ? wifi_iq_pack : '0;
                if (!wifi_iq_valid && tx_active) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            k_reg    <= '0;
            tail_cnt <= '0;
        end else begin
            state    <= state_next;
            k_reg    <= k_next;
            tail_cnt <= tail_next;
        end
    end

    assign cap_zero   = (cap_data == '0);
    assign tail_limit = (tail_len == '0) ? (TAIL_WIDTH+1)'(1) : {1'b0, tail_len};
    assign tail_after = {1'b0, tail_cnt} + (TAIL_WIDTH+1)'(1);

    always_comb begin
        state_next = state;
        k_next     = k_reg;
        tail_next  = tail_cnt;
        gain       = UNITY_GAIN;
        if (cap_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (!cap_zero) begin
                        if (ramp_en) begin
                            gain       = {1'b0, K_ONE};
                            k_next     = K_SECOND;
                            state_next = (K_LAST == K_ONE) ? ST_ACTIVE : ST_RAMP;
                        end else begin
                            state_next = ST_ACTIVE;
                        end
                    end
                end
                ST_RAMP: begin
                    gain   = {1'b0, k_reg};
                    k_next = k_reg + K_ONE;
                    if (k_reg == K_LAST) begin
                        state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (cap_zero) begin
                        state_next = (tail_limit <= (TAIL_WIDTH+1)'(1)) ? ST_IDLE : ST_TAIL;
                        tail_next  = TAIL_WIDTH'(1);
                    end
                end
                ST_TAIL: begin
                    if (!cap_zero) begin
                        state_next = ST_ACTIVE;
                    end else if (tail_after >= tail_limit) begin
                        state_next = ST_IDLE;
                    end else begin
                        tail_next = tail_after[TAIL_WIDTH-1:0];
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Swapping ahead of the scaler keeps the whole output path registered.
    assign lane0 = iq_swap ? cap_data[SW-1:IQ_DATA_WIDTH] : cap_data[IQ_DATA_WIDTH-1:0];
    assign lane1 = iq_swap ? cap_data[IQ_DATA_WIDTH-1:0] : cap_data[SW-1:IQ_DATA_WIDTH];

    tx_ramp_gain #(
        .IQ_DATA_WIDTH (IQ_DATA_WIDTH),
        .RAMP_SHIFT    (RAMP_SHIFT)
    ) u_gain (
        .clk          (clk),
        .rstn         (rstn),
        .sample_valid (cap_valid),
        .x0           (lane0),
        .x1           (lane1),
        .gain         (gain),
        .scaled_valid (dac_valid),
        .y0           (y0),
        .y1           (y1)
    );

    assign dac_data  = {y1, y0};
    assign tx_active = (state != ST_IDLE);

endmodule

// File: tb/tb_tx_iq_dac_pacer.sv
// Scoreboard bench: stimulus acts as the upstream stage, a monitor checks every DAC strobe.
`timescale 1ns/1ps
module tb_tx_iq_dac_pacer;

    localparam int W  = 16;
    localparam int SW = 32;
    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic [7:0]    rate_div;
    logic [TW-1:0] tail_len;
    logic          ramp_en;
    logic          iq_swap;
    logic [SW-1:0] wifi_iq_pack;
    logic          wifi_iq_valid;
    logic          wifi_iq_ready;
    logic [SW-1:0] dac_data;
    logic          dac_valid;
    logic          tx_active;
    logic          underrun;

    typedef struct {
        logic [SW-1:0] data;
        logic          active;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    tx_iq_dac_pacer #(
        .IQ_DATA_WIDTH (W),
        .RAMP_SHIFT    (4),
        .TAIL_WIDTH    (TW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rate_div      (rate_div),
        .tail_len      (tail_len),
        .ramp_en       (ramp_en),
        .iq_swap       (iq_swap),
        .wifi_iq_pack  (wifi_iq_pack),
        .wifi_iq_valid (wifi_iq_valid),
        .wifi_iq_ready (wifi_iq_ready),
        .dac_data      (dac_data),
        .dac_valid     (dac_valid),
        .tx_active     (tx_active),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [SW-1:0] pk(input int q, input int i);
        return {16'(q), 16'(i)};
    endfunction

    task automatic check_output(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Answer the next ready strobe with one sample and log what the DAC must show for it.
    task automatic apply_stimulus(input logic [SW-1:0] pack, input logic vld,
                                  input logic [SW-1:0] exp_data, input logic exp_active,
                                  output int ready_cyc);
        int budget = 300;
        ready_cyc = -1;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            if (wifi_iq_ready === 1'b1) begin
                ready_cyc = cyc;
                break;
            end
        end
        if (ready_cyc < 0) begin
            check_output("ready_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        #1;
        wifi_iq_pack  = pack;
        wifi_iq_valid = vld;
        sb.push_back('{data: exp_data, active: exp_active, cyc: ready_cyc + 3});
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && dac_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("unexpected_output", 32'd0, 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check_output("dac_data", dac_data, mon_e.data);
                check_output("tx_active", 32'(tx_active), 32'(mon_e.active));
                check_output("valid_latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc;
        int prev;
        rstn          = 1'b0;
        rate_div      = 8'd0;
        tail_len      = TW'(3);
        ramp_en       = 1'b1;
        iq_swap       = 1'b0;
        wifi_iq_pack  = 32'hDEADBEEF;
        wifi_iq_valid = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check_output("reset_ready", 32'(wifi_iq_ready), 32'd0);
        check_output("reset_dac_valid", 32'(dac_valid), 32'd0);
        check_output("reset_dac_data", dac_data, 32'd0);
        check_output("reset_tx_active", 32'(tx_active), 32'd0);
        check_output("reset_underrun", 32'(underrun), 32'd0);

        rate_div     = 8'd4;
        wifi_iq_pack = '0;
        @(negedge clk);
        #2;
        rstn = 1'b1;

        // Pacing at rate_div=4, then at full rate.
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);
        prev = rc;
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);
        check_output("ready_period_div4_a", 32'(rc - prev), 32'd5);
        prev = rc;
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);
        check_output("ready_period_div4_b", 32'(rc - prev), 32'd5);
        rate_div = 8'd0;
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);
        prev = rc;
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);
        check_output("ready_period_div0", 32'(rc - prev), 32'd1);

        // Ramp: 16000 scaled by k/16 for k=1..15, then unity.
        for (int n = 1; n <= 15; n++) begin
            apply_stimulus(pk(16000, 16000), 1'b1, pk(1000 * n, 1000 * n), 1'b1, rc);
        end
        apply_stimulus(pk(16000, 16000), 1'b1, pk(16000, 16000), 1'b1, rc);
        apply_stimulus(pk(16000, 16000), 1'b1, pk(16000, 16000), 1'b1, rc);

        // Tail with tail_len=3: two zeros and recovery, then three zeros to idle.
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b1, rc);
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b1, rc);
        apply_stimulus(pk(16000, 16000), 1'b1, pk(16000, 16000), 1'b1, rc);
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b1, rc);
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b1, rc);
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);

        // Negative ramp: k=1 on I=-1/Q=-32768, zeros through k=14, k=15 on I=-32768/Q=-1.
        apply_stimulus(pk(-32768, -1), 1'b1, pk(-2048, -1), 1'b1, rc);
        repeat (13) apply_stimulus(32'd0, 1'b1, 32'd0, 1'b1, rc);
        apply_stimulus(pk(-1, -32768), 1'b1, pk(-1, -30720), 1'b1, rc);
        check_output("underrun_clear", 32'(underrun), 32'd0);

        // Underrun while active becomes a zero sample and the flag sticks.
        apply_stimulus(32'h12345678, 1'b0, 32'd0, 1'b1, rc);
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b1, rc);
        check_output("underrun_set", 32'(underrun), 32'd1);
        apply_stimulus(32'd0, 1'b1, 32'd0, 1'b0, rc);

        // No ramp, swapped halves.
        ramp_en = 1'b0;
        iq_swap = 1'b1;
        apply_stimulus(pk(-5, 100), 1'b1, pk(100, -5), 1'b1, rc);
        apply_stimulus(pk(8, 7), 1'b1, pk(7, 8), 1'b1, rc);
        apply_stimulus(pk(2, 1), 1'b1, pk(1, 2), 1'b1, rc);
        apply_stimulus(pk(4, 3), 1'b1, pk(3, 4), 1'b1, rc);
        apply_stimulus(pk(6, 5), 1'b1, pk(5, 6), 1'b1, rc);
        apply_stimulus(pk(-7, -6), 1'b1, pk(-6, -7), 1'b1, rc);
        check_output("underrun_sticky", 32'(underrun), 32'd1);

        // Mid-burst reset clears everything immediately; in-flight samples are dropped.
        rstn = 1'b0;
        #1;
        sb.delete();
        check_output("midreset_ready", 32'(wifi_iq_ready), 32'd0);
        check_output("midreset_dac_valid", 32'(dac_valid), 32'd0);
        check_output("midreset_dac_data", dac_data, 32'd0);
        check_output("midreset_tx_active", 32'(tx_active), 32'd0);
        check_output("midreset_underrun", 32'(underrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_output("held_reset_dac_valid", 32'(dac_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_iq_dac_pacer.md
Name: tx_iq_dac_pacer

Overview:
- Sits directly downstream of the tx I/Q interface stage and drives the DAC-side sample bus.
- Paces that stage by strobing its ready input at the programmed sample rate, then captures each returned I/Q word.
- Applies a linear ramp-up gain at burst start, tracks burst activity and raises tx_active for ATR/PA control.
- Outputs the DAC word with an optional I/Q swap.

Parameters:
- IQ_DATA_WIDTH, 16, width of each of I and Q.
- RAMP_SHIFT, 4, ramp length is 2^RAMP_SHIFT samples.
- TAIL_WIDTH, 10, width of the tail_len input and the tail counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rate_div  in  8  wifi_iq_ready pulses once every rate_div+1 clocks.
- tail_len  in  TAIL_WIDTH  consecutive zero samples that end a burst; 0 is treated as 1.
- ramp_en  in  1  1 enables the start-of-burst ramp.
- iq_swap  in  1  1 swaps the I and Q halves at the output.
- wifi_iq_pack  in  2*IQ_DATA_WIDTH  {Q,I} from the upstream stage, valid the cycle after the ready strobe.
- wifi_iq_valid  in  1  upstream data-valid indication.
- wifi_iq_ready  out  1  one-cycle sample strobe to the upstream stage.
- dac_data  out  2*IQ_DATA_WIDTH  {Q,I} to the DAC.
- dac_valid  out  1  one-cycle strobe per output sample.
- tx_active  out  1  high in RAMP, ACTIVE and TAIL.
- underrun  out  1  sticky; set when wifi_iq_valid=0 at capture while tx_active=1; cleared only by reset.

Behaviour:
- Reset (asynchronous, rstn=0): every register clears. wifi_iq_ready=0, dac_data=0, dac_valid=0, tx_active=0, underrun=0, state=IDLE, divider=0.
- Divider:
  - Counts 0..rate_div and wraps to 0 at rate_div.
  - wifi_iq_ready=1 in the cycle the count equals rate_div.
  - rate_div=0 gives ready every cycle.
  - A change to rate_div takes effect immediately through the compare; if the count is already above the new value, it wraps on reaching 255.
- Capture: with ready high in cycle t, wifi_iq_pack is registered at the end of cycle t+1 (cap_valid). A capture with wifi_iq_valid=0 is treated as a zero sample.
- Zero test: a sample is "zero" when all 2*IQ_DATA_WIDTH bits are 0.
- State machine (evaluated on each capture):
  - IDLE: nonzero sample goes to RAMP with k=1 if ramp_en=1, else to ACTIVE. Zero samples are still output, as 0.
  - RAMP: k increments once per capture, zero or not. When k=2^RAMP_SHIFT-1 has been applied, go to ACTIVE. ramp_en is sampled only at IDLE exit.
  - ACTIVE: zero sample goes to TAIL with tail_cnt=1.
  - TAIL: nonzero sample returns to ACTIVE without re-ramping. A zero sample with tail_cnt+1 >= max(tail_len,1) goes to IDLE; otherwise tail_cnt increments. With tail_len=1, one zero sample in ACTIVE goes straight to IDLE.
- Gain:
  - In RAMP, each half is computed as (x*k)>>>RAMP_SHIFT: signed, arithmetic shift, truncation toward -inf.
  - The product width is IQ_DATA_WIDTH+RAMP_SHIFT+1; the result is IQ_DATA_WIDTH wide and cannot overflow.
  - Other states pass the sample through.
- Output: registered one cycle after capture. dac_valid=1 in cycle t+3 relative to ready in cycle t, and dac_data holds {Q,I}, or {I,Q} when iq_swap=1.
- tx_active: updates in the same cycle as the dac_data of the sample that caused the transition.
- Pipeline: fully pipelined. rate_div=0 sustains one output per clock with no bubbles.

Decomposition:
- Shared package: state encoding for IDLE/RAMP/ACTIVE/TAIL, the product-width constant, and the zero-sample width.
- Sub-module tx_ramp_gain: a registered two-lane signed scaler taking x and k, with RAMP_SHIFT as a parameter.
- Divider, capture, FSM and output mux stay in the top level.

Test Plan:
- Reset and pacing: rate_div=4 -> wifi_iq_ready pulses every 5 clocks; with rate_div=0 it pulses every clock. dac_valid follows each ready by 3 clocks. All outputs are 0 while rstn=0.
- Ramp: RAMP_SHIFT=4, ramp_en=1, a stream of I=Q=16000 after zeros:
  - the first 15 outputs are 1000,2000,...,15000;
  - the 16th is 16000;
  - tx_active rises with the first output.
- Negative ramp: I=-1, k=1 -> output -1 (floor). I=-32768, k=15 -> -30720.
- Tail: tail_len=3.
  - Two zeros then a nonzero -> returns to ACTIVE, no re-ramp, tx_active stays 1.
  - Three zeros -> IDLE; tx_active falls with the third zero's output.
- ramp_en=0 and iq_swap=1: I=100, Q=-5 -> first output passes unscaled with halves swapped, dac_data={100,-5}.
- Underrun: hold wifi_iq_valid=0 for one capture in ACTIVE -> output 0, underrun=1 and stays 1. Assert rstn=0 mid-burst -> all outputs return to 0 at once.
